// File: rtl/vga_scan_timing.sv
// VGA raster scan generator: pixel-enable divider, row/col counters, blanking flag,
// and a sync/blank delay line that lines the pins up with the display's colour reply.
module vga_scan_timing #(
  parameter int CLK_DIV   = 2,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int COLOR_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] row,
  output logic [31:0] col,
  output logic        vnotactive,
  output logic        pix_en,
  output logic        frame_start,
  input  logic        red_in,
  input  logic        green_in,
  input  logic        blue_in,
  output logic        vga_r,
  output logic        vga_g,
  output logic        vga_b,
  output logic        vga_hs,
  output logic        vga_vs
);

  localparam logic [31:0] H_LAST = 32'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [31:0] V_LAST = 32'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [31:0] H_ACT  = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT  = 32'(V_ACTIVE);
  localparam logic [31:0] HS_BEG = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_BEG = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END = 32'(V_ACTIVE + V_FP + V_SYNC);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en_q, pix_en_d;
  logic [31:0]      col_q, col_d;
  logic [31:0]      row_q, row_d;
  logic             vnot_q, vnot_d;
  logic             fs_q, fs_d;

  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic r_q, r_d;
  logic g_q, g_d;
  logic b_q, b_d;

  logic       hs_raw, vs_raw;
  logic [2:0] dly_out;

  // pix_en is registered so it stays low through reset even when CLK_DIV is 1;
  // the counters advance on the edge that closes a pix_en cycle.
  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    pix_en_d = (div_d == DIV_LAST);
    col_d    = col_q;
    row_d    = row_q;
    fs_d     = 1'b0;
    if (pix_en_q) begin
      if (col_q == H_LAST) begin
        col_d = '0;
        if (row_q == V_LAST) begin
          row_d = '0;
          fs_d  = 1'b1;
        end else begin
          row_d = row_q + 32'd1;
        end
      end else begin
        col_d = col_q + 32'd1;
      end
    end
    vnot_d = (col_d >= H_ACT) || (row_d >= V_ACT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      vnot_q   <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
      col_q    <= col_d;
      row_q    <= row_d;
      vnot_q   <= vnot_d;
      fs_q     <= fs_d;
    end
  end

  assign hs_raw = ~((col_q >= HS_BEG) && (col_q < HS_END));
  assign vs_raw = ~((row_q >= VS_BEG) && (row_q < VS_END));

  // Delay {hs, vs, active} by the display's colour latency; stages reset to blanked idle.
  generate
    if (COLOR_LAT == 0) begin : g_no_dly
      assign dly_out = {hs_raw, vs_raw, ~vnot_q};
    end else begin : g_dly
      logic [2:0] dly_q [COLOR_LAT];
      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int i = 0; i < COLOR_LAT; i++) dly_q[i] <= 3'b110;
        end else begin
          dly_q[0] <= {hs_raw, vs_raw, ~vnot_q};
          for (int i = 1; i < COLOR_LAT; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign dly_out = dly_q[COLOR_LAT-1];
    end
  endgenerate

  always_comb begin
    hs_d = dly_out[2];
    vs_d = dly_out[1];
    r_d  = red_in   & dly_out[0];
    g_d  = green_in & dly_out[0];
    b_d  = blue_in  & dly_out[0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      r_q  <= 1'b0;
      g_q  <= 1'b0;
      b_q  <= 1'b0;
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
    end
  end

  assign row         = row_q;
  assign col         = col_q;
  assign vnotactive  = vnot_q;
  assign pix_en      = pix_en_q;
  assign frame_start = fs_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: two small-raster instances (CLK_DIV=2/COLOR_LAT=1 and
// CLK_DIV=1/COLOR_LAT=0) checked every cycle against a closed-form scan model.
module tb_vga_scan_timing;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6, HT = HA + HF + HS + HB;
  localparam int VA = 12, VF = 2, VS = 2, VB = 4, VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int TOTAL_CYC = 4700;
  localparam int MID_RST_FROM = 2900;

  logic clk = 1'b0;
  logic rst [2];
  logic red [2];
  logic grn [2];
  logic blu [2];

  logic [31:0] rowO [2];
  logic [31:0] colO [2];
  logic vnO [2], pixO [2], fsO [2];
  logic rO [2], gO [2], bO [2], hsO [2], vsO [2];

  logic [2:0] sbA [$];
  logic [2:0] sbB [$];

  int k [2];
  int pPrev [2];
  logic redPrev [2], grnPrev [2], bluPrev [2];
  logic [31:0] colPrevObs [2];
  int hsRun [2], vsRun [2], rRun [2];
  bit hsRunOk [2], vsRunOk [2], rRunOk [2];
  logic hsLast [2], vsLast [2], rLast [2];
  int lastFsK [2];
  bit fsSeen [2];
  logic wasRst [2];
  int cyc;
  int phase;
  bit midDone;
  int vectorCnt;
  int missCnt;

  always #5 clk = ~clk;

  vga_scan_timing #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .COLOR_LAT(1)
  ) uA (
    .CLK(clk), .RST(rst[0]), .row(rowO[0]), .col(colO[0]), .vnotactive(vnO[0]),
    .pix_en(pixO[0]), .frame_start(fsO[0]), .red_in(red[0]), .green_in(grn[0]),
    .blue_in(blu[0]), .vga_r(rO[0]), .vga_g(gO[0]), .vga_b(bO[0]),
    .vga_hs(hsO[0]), .vga_vs(vsO[0])
  );

  vga_scan_timing #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .COLOR_LAT(0)
  ) uB (
    .CLK(clk), .RST(rst[1]), .row(rowO[1]), .col(colO[1]), .vnotactive(vnO[1]),
    .pix_en(pixO[1]), .frame_start(fsO[1]), .red_in(red[1]), .green_in(grn[1]),
    .blue_in(blu[1]), .vga_r(rO[1]), .vga_g(gO[1]), .vga_b(bO[1]),
    .vga_hs(hsO[1]), .vga_vs(vsO[1])
  );

  function automatic int divOf(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int latOf(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  // pix_en first rises one clock after release, so with CLK_DIV=1 the scan trails by one clock
  function automatic int firstFsK(input int d);
    return (d == 0) ? FT * 2 : FT + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectorCnt++;
    if (got !== want) begin
      missCnt++;
      $display("[TB] FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, got, want);
    end
  endtask

  task automatic sbReset(input int d);
    if (d == 0) sbA.delete(); else sbB.delete();
    for (int i = 0; i <= latOf(d); i++) begin
      if (d == 0) sbA.push_back(3'b110); else sbB.push_back(3'b110);
    end
  endtask

  task automatic sbPushPop(input int d, input logic [2:0] v, output logic [2:0] front);
    if (d == 0) sbA.push_back(v); else sbB.push_back(v);
    front = 3'b110;
    if (d == 0) front = sbA.pop_front(); else front = sbB.pop_front();
  endtask

  task automatic stepModel(input int d, input logic inRst);
    int D, p, eCol, eRow;
    logic eVn, ePix, eFs, eHs, eVs;
    logic [2:0] pin;
    string pf;
    D  = divOf(d);
    pf = (d == 0) ? "A." : "B.";
    if (inRst) begin
      k[d] = 0; pPrev[d] = 0; sbReset(d);
      hsRunOk[d] = 0; vsRunOk[d] = 0; rRunOk[d] = 0; fsSeen[d] = 0;
    end else begin
      k[d]++;
    end
    // pixel index = number of pix_en cycles completed since the reset edge
    p = k[d] / D - ((D == 1) ? 1 : 0);
    if (p < 0) p = 0;
    eCol = p % HT;
    eRow = (p / HT) % VT;
    eVn  = (eCol >= HA) || (eRow >= VA);
    ePix = (k[d] >= 1) && (k[d] % D == D - 1);
    eFs  = (p != pPrev[d]) && (p % FT == 0);
    pPrev[d] = p;
    eHs = !((eCol >= HA + HF) && (eCol < HA + HF + HS));
    eVs = !((eRow >= VA + VF) && (eRow < VA + VF + VS));

    checkOutput({pf, "col"}, colO[d], 32'(eCol));
    checkOutput({pf, "row"}, rowO[d], 32'(eRow));
    checkOutput({pf, "vnotactive"}, 32'(vnO[d]), 32'(eVn));
    checkOutput({pf, "pix_en"}, 32'(pixO[d]), 32'(ePix));
    checkOutput({pf, "frame_start"}, 32'(fsO[d]), 32'(eFs));

    sbPushPop(d, {eHs, eVs, ~eVn}, pin);
    checkOutput({pf, "vga_hs"}, 32'(hsO[d]), 32'(pin[2]));
    checkOutput({pf, "vga_vs"}, 32'(vsO[d]), 32'(pin[1]));
    checkOutput({pf, "vga_r"}, 32'(rO[d]), 32'(redPrev[d] & pin[0]));
    checkOutput({pf, "vga_g"}, 32'(gO[d]), 32'(grnPrev[d] & pin[0]));
    checkOutput({pf, "vga_b"}, 32'(bO[d]), 32'(bluPrev[d] & pin[0]));

    if (d == 0 && !inRst && k[d] == HT * D - 1) begin
      checkOutput("A.lineEndCol", colO[d], 32'(HT - 1));
      checkOutput("A.lineEndRow", rowO[d], 32'd0);
    end
    if (d == 0 && !inRst && k[d] == HT * D) begin
      checkOutput("A.wrapCol", colO[d], 32'd0);
      checkOutput("A.wrapRow", rowO[d], 32'd1);
    end

    // pulse-width trackers on the observed pins
    if (hsO[d] == 1'b0) begin
      if (hsLast[d]) begin hsRun[d] = 1; hsRunOk[d] = !inRst; end
      else hsRun[d]++;
    end else if (!hsLast[d] && hsRunOk[d]) begin
      checkOutput({pf, "hsWidth"}, 32'(hsRun[d]), 32'(HS * D));
      hsRunOk[d] = 0;
    end
    if (vsO[d] == 1'b0) begin
      if (vsLast[d]) begin vsRun[d] = 1; vsRunOk[d] = !inRst; end
      else vsRun[d]++;
    end else if (!vsLast[d] && vsRunOk[d]) begin
      checkOutput({pf, "vsWidth"}, 32'(vsRun[d]), 32'(VS * HT * D));
      vsRunOk[d] = 0;
    end
    if (rO[d] == 1'b1) begin
      if (!rLast[d]) begin rRun[d] = 1; rRunOk[d] = (phase == 1) && !inRst; end
      else rRun[d]++;
    end else if (rLast[d] && rRunOk[d]) begin
      checkOutput({pf, "redWidth"}, 32'(rRun[d]), 32'(D));
      rRunOk[d] = 0;
    end
    hsLast[d] = hsO[d];
    vsLast[d] = vsO[d];
    rLast[d]  = rO[d];

    if (fsO[d] && !inRst) begin
      if (fsSeen[d]) checkOutput({pf, "frameLen"}, 32'(k[d] - lastFsK[d]), 32'(FT * D));
      else checkOutput({pf, "firstFrame"}, 32'(k[d]), 32'(firstFsK(d)));
      fsSeen[d]  = 1;
      lastFsK[d] = k[d];
    end
  endtask

  task automatic applyStimulus();
    phase = (cyc < 1400) ? 0 : 1;
    if (cyc >= 2) begin
      rst[1] = 1'b0;
      rst[0] = 1'b0;
      if (!midDone && cyc >= MID_RST_FROM && colO[0] == 32'd12 && rowO[0] == 32'd10) begin
        rst[0]  = 1'b1;
        midDone = 1;
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (phase == 0) red[d] = 1'b1;
      else if (latOf(d) == 1) red[d] = (colPrevObs[d] == 32'd5);
      else red[d] = (colO[d] == 32'd5);
      grn[d] = 1'($urandom_range(0, 1));
      blu[d] = 1'($urandom_range(0, 1));
      redPrev[d] = red[d];
      grnPrev[d] = grn[d];
      bluPrev[d] = blu[d];
      colPrevObs[d] = colO[d];
    end
  endtask

  initial begin
    vectorCnt = 0;
    missCnt   = 0;
    midDone   = 0;
    phase     = 0;
    cyc       = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; red[d] = 1'b0; grn[d] = 1'b0; blu[d] = 1'b0;
      redPrev[d] = 1'b0; grnPrev[d] = 1'b0; bluPrev[d] = 1'b0;
      colPrevObs[d] = '0; k[d] = 0; pPrev[d] = 0;
      hsRun[d] = 0; vsRun[d] = 0; rRun[d] = 0;
      hsRunOk[d] = 0; vsRunOk[d] = 0; rRunOk[d] = 0;
      hsLast[d] = 1'b1; vsLast[d] = 1'b1; rLast[d] = 1'b0;
      lastFsK[d] = 0; fsSeen[d] = 0;
    end
    for (int c = 0; c < TOTAL_CYC; c++) begin
      wasRst[0] = rst[0];
      wasRst[1] = rst[1];
      @(posedge clk);
      #1;
      cyc = c;
      for (int d = 0; d < 2; d++) stepModel(d, wasRst[d]);
      applyStimulus();
    end
    checkOutput("A.midRstSeen", 32'(midDone), 32'd1);
    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectorCnt, missCnt);
    $finish;
  end

endmodule
